// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame FSM states,
// data width, and the sizing rule for the baud counter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Width needed to count 0..clks_per_bit-1; never narrower than one bit.
  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// clr restarts the count so a new frame's start bit gets a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit-period counter, wraps at the terminal count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  // Terminal-count flag.
  always_comb begin
    tick = (cnt == LAST);
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin grant over valid/ready, then
// frames the granted byte as start, 8 data bits LSB first, optional even
// parity, and STOP_BITS stop bits on a registered, idle-high tx line.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       done_id
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_W - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t            state, state_d;
  logic [UART_DATA_W-1:0] shreg;
  logic [2:0]             bit_idx;
  logic                   stop_cnt;
  logic                   id;
  logic                   parity_bit;
  logic                   last_grant;
  logic                   tick;
  logic                   sel;
  logic                   xfer;
  logic                   tx_d;
  logic [UART_DATA_W-1:0] xfer_data;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer),
    .tick  (tick)
  );

  // Round-robin select: a lone valid wins; on contention the requester that
  // did not win last time goes next.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch can never be inferred.
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant;
    else if (req1_valid)          sel = 1'b1;
    xfer      = (state == IDLE) && en && (req0_valid || req1_valid);
    xfer_data = sel ? req1_data : req0_data;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic: each non-idle state advances only on a baud tick.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (xfer) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && bit_idx == LAST_BIT)
                 state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick && stop_cnt == STOP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes, busy, and the tx level for the state about to be
  // entered so the registered line lines up with the state register.
  always_comb begin
    req0_ready = xfer && !sel;
    req1_ready = xfer && sel;
    busy       = (state != IDLE);
    tx_d       = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = (state == DATA && tick) ? shreg[1] : shreg[0];
      PARITY:  tx_d = parity_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame datapath: latch byte and owner on grant, shift per data bit,
  // count stop bits, and pulse frame_done on entry to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      id         <= 1'b0;
      parity_bit <= 1'b0;
      last_grant <= 1'b1;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      tx         <= tx_d;
      case (state)
        IDLE: if (xfer) begin
          shreg      <= xfer_data;
          parity_bit <= ^xfer_data;
          id         <= sel;
          last_grant <= sel;
          bit_idx    <= '0;
          stop_cnt   <= 1'b0;
        end
        DATA: if (tick) begin
          shreg <= shreg >> 1;
          if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 3'd1;
        end
        STOP: if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            frame_done <= 1'b1;
            done_id    <= id;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
